// File: rtl/crd_arb.sv
// crd_arb: two-requester round-robin arbiter in front of a shared GLB coordinate read port.
//
// Ports:
//   clk, rst, CCUARB_Rst                : clock, synchronous reset, synchronous soft clear
//   FPSARB_* / ARBFPS_*                 : requester 0 (FPS) address request and data response
//   KNNARB_* / ARBKNN_*                 : requester 1 (KNN) address request and data response
//   ARBGLB_* / GLBARB_*                 : shared GLB address request and in-order data return
//   ARBCCU_Idle, ARBCCU_Err             : idle status, sticky protocol error
//
// The address and data paths are purely combinational. A small FIFO of requester IDs
// remembers who issued each outstanding GLB read, so that in-order read data can be
// routed back to the requester that asked for it.
module crd_arb #(
    parameter int unsigned IDX_WIDTH  = 10,
    parameter int unsigned SRAM_WIDTH = 256,
    parameter int unsigned TAG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CCUARB_Rst,

    input  logic [IDX_WIDTH-1:0]  FPSARB_CrdAddr,
    input  logic                  FPSARB_CrdAddrVld,
    output logic                  ARBFPS_CrdAddrRdy,
    output logic [SRAM_WIDTH-1:0] ARBFPS_Crd,
    output logic                  ARBFPS_CrdVld,
    input  logic                  FPSARB_CrdRdy,

    input  logic [IDX_WIDTH-1:0]  KNNARB_CrdAddr,
    input  logic                  KNNARB_CrdAddrVld,
    output logic                  ARBKNN_CrdAddrRdy,
    output logic [SRAM_WIDTH-1:0] ARBKNN_Crd,
    output logic                  ARBKNN_CrdVld,
    input  logic                  KNNARB_CrdRdy,

    output logic [IDX_WIDTH-1:0]  ARBGLB_CrdAddr,
    output logic                  ARBGLB_CrdAddrVld,
    input  logic                  GLBARB_CrdAddrRdy,
    input  logic [SRAM_WIDTH-1:0] GLBARB_Crd,
    input  logic                  GLBARB_CrdVld,
    output logic                  ARBGLB_CrdRdy,

    output logic                  ARBCCU_Idle,
    output logic                  ARBCCU_Err
);

    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

    logic                 r_pri;      // 0: FPS wins a tie, 1: KNN wins a tie
    logic                 r_lock;     // an offered address is waiting for GLB ready
    logic                 r_lock_id;
    logic                 r_err;
    logic [TAG_DEPTH-1:0] r_tag;      // requester ID per outstanding read
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_cnt;

    logic w_clr;
    logic w_win;
    logic w_win_vld;
    logic w_full;
    logic w_empty;
    logic w_grant;
    logic w_head;
    logic w_pop;

    assign w_clr   = rst | CCUARB_Rst;
    assign w_full  = (r_cnt == FULL_CNT);
    assign w_empty = (r_cnt == '0);

    // Winner selection; a stalled offer keeps its requester so the GLB address stays stable.
    always_comb begin
        w_win = 1'b0;
        if (r_lock) begin
            w_win = r_lock_id;
        end else if (FPSARB_CrdAddrVld && KNNARB_CrdAddrVld) begin
            w_win = r_pri;
        end else if (KNNARB_CrdAddrVld) begin
            w_win = 1'b1;
        end
    end

    assign w_win_vld         = w_win ? KNNARB_CrdAddrVld : FPSARB_CrdAddrVld;
    assign ARBGLB_CrdAddrVld = w_win_vld & ~w_full;
    assign ARBGLB_CrdAddr    = !w_win_vld ? '0 : (w_win ? KNNARB_CrdAddr : FPSARB_CrdAddr);

    assign w_grant           = w_win_vld & GLBARB_CrdAddrRdy & ~w_full;
    assign ARBFPS_CrdAddrRdy = w_grant & ~w_win;
    assign ARBKNN_CrdAddrRdy = w_grant & w_win;

    // Response routing follows the oldest outstanding tag.
    assign w_head        = r_tag[r_rd_ptr];
    assign ARBGLB_CrdRdy = ~w_empty & (w_head ? KNNARB_CrdRdy : FPSARB_CrdRdy);
    assign ARBFPS_CrdVld = GLBARB_CrdVld & ~w_empty & ~w_head;
    assign ARBKNN_CrdVld = GLBARB_CrdVld & ~w_empty & w_head;
    assign ARBFPS_Crd    = GLBARB_Crd;
    assign ARBKNN_Crd    = GLBARB_Crd;
    assign w_pop         = GLBARB_CrdVld & ARBGLB_CrdRdy;

    assign ARBCCU_Idle = w_empty & ~FPSARB_CrdAddrVld & ~KNNARB_CrdAddrVld;
    assign ARBCCU_Err  = r_err;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_pri     <= 1'b0;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_err     <= 1'b0;
            r_tag     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_grant) begin
                r_tag[r_wr_ptr] <= w_win;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_pri           <= ~w_win;
                r_lock          <= 1'b0;
            end else if (ARBGLB_CrdAddrVld) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_win;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_grant && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_grant && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end

            // Read data with nothing outstanding is an orphan response.
            if (GLBARB_CrdVld && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crd_arb.sv
// tb_crd_arb: directed stimulus for crd_arb with a queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_crd_arb;

    localparam int IW = 10;
    localparam int SW = 256;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          CCUARB_Rst;
    logic [IW-1:0] FPSARB_CrdAddr;
    logic          FPSARB_CrdAddrVld;
    logic          ARBFPS_CrdAddrRdy;
    logic [SW-1:0] ARBFPS_Crd;
    logic          ARBFPS_CrdVld;
    logic          FPSARB_CrdRdy;
    logic [IW-1:0] KNNARB_CrdAddr;
    logic          KNNARB_CrdAddrVld;
    logic          ARBKNN_CrdAddrRdy;
    logic [SW-1:0] ARBKNN_Crd;
    logic          ARBKNN_CrdVld;
    logic          KNNARB_CrdRdy;
    logic [IW-1:0] ARBGLB_CrdAddr;
    logic          ARBGLB_CrdAddrVld;
    logic          GLBARB_CrdAddrRdy;
    logic [SW-1:0] GLBARB_Crd;
    logic          GLBARB_CrdVld;
    logic          ARBGLB_CrdRdy;
    logic          ARBCCU_Idle;
    logic          ARBCCU_Err;

    crd_arb #(
        .IDX_WIDTH  (IW),
        .SRAM_WIDTH (SW),
        .TAG_DEPTH  (TD)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .CCUARB_Rst        (CCUARB_Rst),
        .FPSARB_CrdAddr    (FPSARB_CrdAddr),
        .FPSARB_CrdAddrVld (FPSARB_CrdAddrVld),
        .ARBFPS_CrdAddrRdy (ARBFPS_CrdAddrRdy),
        .ARBFPS_Crd        (ARBFPS_Crd),
        .ARBFPS_CrdVld     (ARBFPS_CrdVld),
        .FPSARB_CrdRdy     (FPSARB_CrdRdy),
        .KNNARB_CrdAddr    (KNNARB_CrdAddr),
        .KNNARB_CrdAddrVld (KNNARB_CrdAddrVld),
        .ARBKNN_CrdAddrRdy (ARBKNN_CrdAddrRdy),
        .ARBKNN_Crd        (ARBKNN_Crd),
        .ARBKNN_CrdVld     (ARBKNN_CrdVld),
        .KNNARB_CrdRdy     (KNNARB_CrdRdy),
        .ARBGLB_CrdAddr    (ARBGLB_CrdAddr),
        .ARBGLB_CrdAddrVld (ARBGLB_CrdAddrVld),
        .GLBARB_CrdAddrRdy (GLBARB_CrdAddrRdy),
        .GLBARB_Crd        (GLBARB_Crd),
        .GLBARB_CrdVld     (GLBARB_CrdVld),
        .ARBGLB_CrdRdy     (ARBGLB_CrdRdy),
        .ARBCCU_Idle       (ARBCCU_Idle),
        .ARBCCU_Err        (ARBCCU_Err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit mdl_on = 1'b0;

    task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding reads as a queue of requester IDs in issue order.
    int q[$];
    int m_pri     = 0;
    bit m_lock    = 1'b0;
    int m_lock_id = 0;
    bit m_err     = 1'b0;

    int      e_win;
    bit      e_avld;
    logic [IW-1:0] e_addr;
    bit      e_fps_ardy;
    bit      e_knn_ardy;
    bit      e_glb_rdy;
    bit      e_fps_vld;
    bit      e_knn_vld;
    bit      e_idle;

    function void compute();
        bit fv;
        bit kv;
        bit wv;
        bit full;
        bit nonempty;
        int head;
        fv = FPSARB_CrdAddrVld;
        kv = KNNARB_CrdAddrVld;
        if (m_lock)        e_win = m_lock_id;
        else if (fv && kv) e_win = m_pri;
        else               e_win = kv ? 1 : 0;
        wv         = (e_win == 1) ? kv : fv;
        full       = (q.size() == TD);
        e_avld     = wv && !full;
        e_addr     = !wv ? '0 : ((e_win == 1) ? KNNARB_CrdAddr : FPSARB_CrdAddr);
        e_fps_ardy = e_avld && GLBARB_CrdAddrRdy && (e_win == 0);
        e_knn_ardy = e_avld && GLBARB_CrdAddrRdy && (e_win == 1);
        nonempty   = (q.size() > 0);
        head       = nonempty ? q[0] : 0;
        e_glb_rdy  = nonempty && ((head == 1) ? KNNARB_CrdRdy : FPSARB_CrdRdy);
        e_fps_vld  = GLBARB_CrdVld && nonempty && (head == 0);
        e_knn_vld  = GLBARB_CrdVld && nonempty && (head == 1);
        e_idle     = (q.size() == 0) && !fv && !kv;
    endfunction

    always @(posedge clk) begin
        if (rst || CCUARB_Rst) begin
            q.delete();
            m_pri  = 0;
            m_lock = 1'b0;
            m_err  = 1'b0;
        end else begin
            compute();
            if (GLBARB_CrdVld && q.size() == 0) m_err = 1'b1;
            if (GLBARB_CrdVld && e_glb_rdy) void'(q.pop_front());
            if (e_avld && GLBARB_CrdAddrRdy) begin
                q.push_back(e_win);
                m_pri  = 1 - e_win;
                m_lock = 1'b0;
            end else if (e_avld) begin
                m_lock    = 1'b1;
                m_lock_id = e_win;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            compute();
            chk("m_addr_vld", ARBGLB_CrdAddrVld, e_avld);
            chk("m_addr", ARBGLB_CrdAddr, e_addr);
            chk("m_fps_addr_rdy", ARBFPS_CrdAddrRdy, e_fps_ardy);
            chk("m_knn_addr_rdy", ARBKNN_CrdAddrRdy, e_knn_ardy);
            chk("m_glb_rdy", ARBGLB_CrdRdy, e_glb_rdy);
            chk("m_fps_vld", ARBFPS_CrdVld, e_fps_vld);
            chk("m_knn_vld", ARBKNN_CrdVld, e_knn_vld);
            chk("m_fps_crd", ARBFPS_Crd, GLBARB_Crd);
            chk("m_knn_crd", ARBKNN_Crd, GLBARB_Crd);
            chk("m_idle", ARBCCU_Idle, e_idle);
            chk("m_err", ARBCCU_Err, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [SW-1:0] d0;
        logic [SW-1:0] d1;
        logic [SW-1:0] d2;
        d0 = {8{32'hD0D0_0001}};
        d1 = {8{32'hD1D1_0002}};
        d2 = {8{32'hD2D2_0003}};

        rst = 1'b1; CCUARB_Rst = 1'b0;
        FPSARB_CrdAddr = '0; FPSARB_CrdAddrVld = 1'b0; FPSARB_CrdRdy = 1'b0;
        KNNARB_CrdAddr = '0; KNNARB_CrdAddrVld = 1'b0; KNNARB_CrdRdy = 1'b0;
        GLBARB_CrdAddrRdy = 1'b0; GLBARB_Crd = '0; GLBARB_CrdVld = 1'b0;
        step();
        step();
        rst = 1'b0;
        mdl_on = 1'b1;
        #1;
        chk("rst_idle", ARBCCU_Idle, 1'b1);
        chk("rst_err", ARBCCU_Err, 1'b0);
        chk("rst_addr_vld", ARBGLB_CrdAddrVld, 1'b0);
        chk("rst_glb_rdy", ARBGLB_CrdRdy, 1'b0);

        // Round robin with both requesting until the tag FIFO fills.
        step();
        FPSARB_CrdAddrVld = 1'b1; FPSARB_CrdAddr = 10'h011;
        KNNARB_CrdAddrVld = 1'b1; KNNARB_CrdAddr = 10'h022;
        GLBARB_CrdAddrRdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_fps_rdy", ARBFPS_CrdAddrRdy, (i % 2 == 0));
            chk("rr_knn_rdy", ARBKNN_CrdAddrRdy, (i % 2 == 1));
            chk("rr_addr", ARBGLB_CrdAddr, (i % 2 == 0) ? 10'h011 : 10'h022);
            step();
        end
        #1;
        chk("full_addr_vld", ARBGLB_CrdAddrVld, 1'b0);
        chk("full_fps_rdy", ARBFPS_CrdAddrRdy, 1'b0);
        GLBARB_CrdVld = 1'b1; GLBARB_Crd = d0; FPSARB_CrdRdy = 1'b1; KNNARB_CrdRdy = 1'b1;
        #1;
        chk("pop_fps_vld", ARBFPS_CrdVld, 1'b1);
        chk("pop_addr_vld", ARBGLB_CrdAddrVld, 1'b0);
        step();
        GLBARB_CrdVld = 1'b0;
        #1;
        chk("refill_addr_vld", ARBGLB_CrdAddrVld, 1'b1);
        chk("refill_fps_rdy", ARBFPS_CrdAddrRdy, 1'b1);
        chk("refill_addr", ARBGLB_CrdAddr, 10'h011);
        step();
        FPSARB_CrdAddrVld = 1'b0; KNNARB_CrdAddrVld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            GLBARB_CrdVld = 1'b1; GLBARB_Crd = SW'(i + 16);
            #1;
            chk("drain_knn_vld", ARBKNN_CrdVld, (i % 2 == 0));
            chk("drain_fps_vld", ARBFPS_CrdVld, (i % 2 == 1));
            step();
        end
        GLBARB_CrdVld = 1'b0;
        #1;
        chk("drain_idle", ARBCCU_Idle, 1'b1);

        // Lock: KNN offer stalls, FPS arrives later, address must not change.
        do_reset();
        GLBARB_CrdAddrRdy = 1'b0;
        KNNARB_CrdAddrVld = 1'b1; KNNARB_CrdAddr = 10'h005;
        #1;
        chk("lk0_addr", ARBGLB_CrdAddr, 10'h005);
        chk("lk0_knn_rdy", ARBKNN_CrdAddrRdy, 1'b0);
        step();
        FPSARB_CrdAddrVld = 1'b1; FPSARB_CrdAddr = 10'h033;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk("lk_addr", ARBGLB_CrdAddr, 10'h005);
            chk("lk_fps_rdy", ARBFPS_CrdAddrRdy, 1'b0);
            step();
        end
        GLBARB_CrdAddrRdy = 1'b1;
        #1;
        chk("lk3_addr", ARBGLB_CrdAddr, 10'h005);
        chk("lk3_knn_rdy", ARBKNN_CrdAddrRdy, 1'b1);
        step();
        KNNARB_CrdAddrVld = 1'b0;
        #1;
        chk("lk4_fps_rdy", ARBFPS_CrdAddrRdy, 1'b1);
        chk("lk4_addr", ARBGLB_CrdAddr, 10'h033);
        step();
        FPSARB_CrdAddrVld = 1'b0;
        GLBARB_CrdVld = 1'b1; GLBARB_Crd = d2;
        #1;
        chk("lk_ret_knn", ARBKNN_CrdVld, 1'b1);
        step();
        #1;
        chk("lk_ret_fps", ARBFPS_CrdVld, 1'b1);
        step();
        GLBARB_CrdVld = 1'b0;

        // In-order return with head-of-line stall on KNN.
        do_reset();
        GLBARB_CrdAddrRdy = 1'b1;
        FPSARB_CrdAddrVld = 1'b1; FPSARB_CrdAddr = 10'h001;
        step();
        FPSARB_CrdAddrVld = 1'b0;
        KNNARB_CrdAddrVld = 1'b1; KNNARB_CrdAddr = 10'h002;
        step();
        KNNARB_CrdAddrVld = 1'b0;
        FPSARB_CrdAddrVld = 1'b1; FPSARB_CrdAddr = 10'h003;
        step();
        FPSARB_CrdAddrVld = 1'b0;
        GLBARB_CrdVld = 1'b1; GLBARB_Crd = d0; FPSARB_CrdRdy = 1'b1; KNNARB_CrdRdy = 1'b0;
        #1;
        chk("ord_d0_fps_vld", ARBFPS_CrdVld, 1'b1);
        chk("ord_d0_fps_crd", ARBFPS_Crd, d0);
        chk("ord_d0_glb_rdy", ARBGLB_CrdRdy, 1'b1);
        step();
        GLBARB_Crd = d1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hol_knn_vld", ARBKNN_CrdVld, 1'b1);
            chk("hol_knn_crd", ARBKNN_Crd, d1);
            chk("hol_glb_rdy", ARBGLB_CrdRdy, 1'b0);
            step();
        end
        KNNARB_CrdRdy = 1'b1;
        #1;
        chk("ord_d1_glb_rdy", ARBGLB_CrdRdy, 1'b1);
        step();
        GLBARB_Crd = d2;
        #1;
        chk("ord_d2_fps_vld", ARBFPS_CrdVld, 1'b1);
        chk("ord_d2_knn_vld", ARBKNN_CrdVld, 1'b0);
        step();
        GLBARB_CrdVld = 1'b0;
        #1;
        chk("ord_idle", ARBCCU_Idle, 1'b1);

        // Orphan data sets a sticky error cleared only by a reset.
        do_reset();
        GLBARB_CrdVld = 1'b1;
        #1;
        chk("orph_glb_rdy", ARBGLB_CrdRdy, 1'b0);
        chk("orph_err_now", ARBCCU_Err, 1'b0);
        step();
        GLBARB_CrdVld = 1'b0;
        #1;
        chk("orph_err_set", ARBCCU_Err, 1'b1);
        step();
        step();
        #1;
        chk("orph_err_hold", ARBCCU_Err, 1'b1);
        CCUARB_Rst = 1'b1;
        step();
        CCUARB_Rst = 1'b0;
        #1;
        chk("orph_err_clr", ARBCCU_Err, 1'b0);

        // Soft clear with two outstanding and priority on KNN.
        GLBARB_CrdAddrRdy = 1'b1;
        KNNARB_CrdAddrVld = 1'b1; KNNARB_CrdAddr = 10'h007;
        step();
        KNNARB_CrdAddrVld = 1'b0;
        FPSARB_CrdAddrVld = 1'b1; FPSARB_CrdAddr = 10'h008;
        step();
        FPSARB_CrdAddrVld = 1'b0;
        #1;
        chk("sc_busy", ARBCCU_Idle, 1'b0);
        CCUARB_Rst = 1'b1;
        step();
        CCUARB_Rst = 1'b0;
        #1;
        chk("sc_idle", ARBCCU_Idle, 1'b1);
        FPSARB_CrdAddrVld = 1'b1; FPSARB_CrdAddr = 10'h009;
        KNNARB_CrdAddrVld = 1'b1; KNNARB_CrdAddr = 10'h00A;
        #1;
        chk("sc_fps_rdy", ARBFPS_CrdAddrRdy, 1'b1);
        chk("sc_addr", ARBGLB_CrdAddr, 10'h009);
        step();
        FPSARB_CrdAddrVld = 1'b0; KNNARB_CrdAddrVld = 1'b0;
        CCUARB_Rst = 1'b1;
        step();
        CCUARB_Rst = 1'b0;
        GLBARB_CrdVld = 1'b1;
        step();
        GLBARB_CrdVld = 1'b0;
        #1;
        chk("sc_orphan_err", ARBCCU_Err, 1'b1);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
